// File: rtl/rot_cmd_fifo_pkg.sv
// Shared defaults and command type for the rotate-command path.
// The FIFO, the sequencer and the bench all import this package.
package rot_pkg;

    localparam int ROT_N     = 3;
    localparam int ROT_DEPTH = 4;

    // The rotate amount needs exactly N bits, because it selects one of 2**N positions.
    function automatic int amt_width(input int n);
        return n;
    endfunction

    typedef struct packed {
        logic [2**ROT_N-1:0] data;
        logic [ROT_N-1:0]    amt;
    } rot_cmd_t;

endpackage

// File: rtl/rot_cmd_fifo.sv
// Command queue in front of the left rotator. It holds data/amount pairs and
// shows the oldest pair on out_data/out_amt, with valid/ready on both sides.
module rot_cmd_fifo
    import rot_pkg::*;
#(
    parameter  int N     = ROT_N,
    parameter  int DEPTH = ROT_DEPTH,
    localparam int W     = 2**N,
    localparam int AMTW  = amt_width(N),
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [AMTW-1:0] in_amt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [AMTW-1:0] out_amt,
    output logic [CW-1:0]   count
);

    logic [W-1:0]    data_mem [DEPTH];
    logic [AMTW-1:0] amt_mem  [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Flush has priority over push and pop. Full and empty depend only on count.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = data_mem[rd_ptr];
    assign out_amt   = amt_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                amt_mem[i]  <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= in_data;
            amt_mem[wr_ptr]  <= in_amt;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own when they overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_cmd_fifo.sv
// Directed bench for rot_cmd_fifo with hand-computed expected values.
// Inputs change 1 time unit after each rising edge and are checked at that same point.
module tb_rot_cmd_fifo;
    import rot_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_amt;
    logic [2:0] count;

    int compareCount  = 0;
    int mismatchCount = 0;

    rot_cmd_fifo #(.N(3), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_amt(out_amt), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model of the downstream rotator, used only for the one known answer.
    function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] dd;
        dd = {d, d} << a;
        return dd[15:8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] a,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".count"}, 32'(count), 32'd0);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        #12;
        checkIdle("por");
        checkOutput("por.out_data", 32'(out_data), 32'h00);
        checkOutput("por.out_amt", 32'(out_amt), 32'h0);
        step();
        reset_n = 1'b1;

        // Assert reset while pushing, away from any clock edge.
        applyStimulus(1'b1, 8'h11, 3'd1, 1'b0, 1'b0);
        step();
        step();
        checkOutput("pre_rst.count", 32'(count), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        checkIdle("async_rst");
        checkOutput("async_rst.out_data", 32'(out_data), 32'h00);
        step();
        checkOutput("rst_held.count", 32'(count), 32'd0);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        checkIdle("post_rst");

        // Push one command, then check the head and the rotator result.
        applyStimulus(1'b1, 8'hA5, 3'd3, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        checkOutput("single.out_valid", 32'(out_valid), 32'd1);
        checkOutput("single.out_data", 32'(out_data), 32'hA5);
        checkOutput("single.out_amt", 32'(out_amt), 32'd3);
        checkOutput("single.count", 32'(count), 32'd1);
        checkOutput("single.rot", 32'(rotl8(out_data, out_amt)), 32'h2D);
        step();
        checkOutput("single.hold_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkIdle("single_pop");

        // Fill the queue. The fifth command has to wait.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 3'(i + 3), 1'b0, 1'b0);
            step();
            checkOutput($sformatf("fill%0d.count", i), 32'(count), 32'(i));
            checkOutput($sformatf("fill%0d.in_ready", i), 32'(in_ready), 32'(i != 4));
        end
        applyStimulus(1'b1, 8'h05, 3'd0, 1'b0, 1'b0);
        step();
        checkOutput("stall.count", 32'(count), 32'd4);
        checkOutput("stall.out_data", 32'(out_data), 32'h01);
        checkOutput("stall.out_amt", 32'(out_amt), 32'd4);
        out_ready = 1'b1;
        step();
        checkOutput("fullpop.count", 32'(count), 32'd3);
        checkOutput("fullpop.out_data", 32'(out_data), 32'h02);
        checkOutput("fullpop.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        checkOutput("stall_accept.count", 32'(count), 32'd4);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            checkOutput($sformatf("drain%0d.out_data", i), 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        checkIdle("drained");

        // Push and pop together at count 2 while the pointers wrap.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 3'(i), 1'b0, 1'b0);
            step();
        end
        checkOutput("conc_pre.count", 32'(count), 32'd2);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 8'(8'h22 + k), 3'(k + 2), 1'b1, 1'b0);
            checkOutput($sformatf("conc%0d.head", k), 32'(out_data), 32'(8'h20 + k));
            checkOutput($sformatf("conc%0d.amt", k), 32'(out_amt), 32'((k) % 8));
            step();
            checkOutput($sformatf("conc%0d.count", k), 32'(count), 32'd2);
        end

        // Flush with a push and a pop in the same cycle. Neither may take effect.
        applyStimulus(1'b1, 8'h28, 3'd7, 1'b0, 1'b0);
        step();
        checkOutput("preflush.count", 32'(count), 32'd3);
        applyStimulus(1'b1, 8'h99, 3'd1, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        checkIdle("flush");
        applyStimulus(1'b1, 8'hF0, 3'd7, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        checkOutput("postflush.out_valid", 32'(out_valid), 32'd1);
        checkOutput("postflush.out_data", 32'(out_data), 32'hF0);
        checkOutput("postflush.out_amt", 32'(out_amt), 32'd7);
        checkOutput("postflush.count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
